sram_controller: RTL and testbench



---
 rtl/sram_controller_pkg.sv | 16 +
 rtl/sram_controller_if.sv | 18 +
 rtl/sram_controller.sv | 106 ++++++++++
 tb/tb_sram_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM front end: FSM encodings, counter width and default device geometry.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int WAIT_CNT_WIDTH  = 4;
   localparam int SRAM_ADDR_WIDTH = 15;
   localparam int SRAM_DATA_WIDTH = 8;
   localparam int SRAM_DEPTH      = 1 << SRAM_ADDR_WIDTH;

endpackage

// File: rtl/sram_controller_if.sv
// Requester-side req/ack bus of the SRAM controller; the master issues accesses, the controller is the slave.
interface sram_controller_if
   import sram_controller_pkg::*;
#(
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ack;
   logic                  busy;

   modport master (output req, we, addr, wdata, input rdata, ack, busy);
   modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_controller.sv
// Sequences one async-SRAM access (setup, strobe, hold) per accepted req; all SRAM pins registered.
// Latency: req edge E0 -> ack in cycle E0 + WAIT_STATES + 3; one access per WAIT_STATES + 4 cycles.
// Backpressure: busy is high outside IDLE and every requester input is ignored until IDLE returns.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
   parameter int WAIT_STATES = 1
)(
   input  logic                  clk,
   input  logic                  reset,
   sram_controller_if.slave      bus,
   output logic [ADDR_WIDTH-1:0] sram_address,
   inout  wire  [DATA_WIDTH-1:0] sram_data,
   output logic                  sram_chip_enable,
   output logic                  sram_write_enable,
   output logic                  sram_output_enable
);

   state_t                    state_q, state_d;
   logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                      we_q, we_d;
   logic [ADDR_WIDTH-1:0]     addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic                      ack_q, ack_d;
   logic                      drive_q, drive_d;
   logic                      ce_n_d, we_n_d, oe_n_d;

   // Strobes and drive enable are computed from the next state so they change only on a clock edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = sram_address;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               state_d = SETUP;
               we_d    = bus.we;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
            end
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = WAIT_CNT_WIDTH'(WAIT_STATES);
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               if (!we_q) rdata_d = sram_data;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ce_n_d  = (state_d == IDLE);
      we_n_d  = !((state_d == STROBE) && we_d);
      oe_n_d  = !((state_d == STROBE) && !we_d);
      drive_d = (state_d != IDLE) && we_d;
      ack_d   = (state_d == HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         we_q               <= 1'b0;
         sram_address       <= '0;
         wdata_q            <= '0;
         rdata_q            <= '0;
         ack_q              <= 1'b0;
         drive_q            <= 1'b0;
         sram_chip_enable   <= 1'b1;
         sram_write_enable  <= 1'b1;
         sram_output_enable <= 1'b1;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         we_q               <= we_d;
         sram_address       <= addr_d;
         wdata_q            <= wdata_d;
         rdata_q            <= rdata_d;
         ack_q              <= ack_d;
         drive_q            <= drive_d;
         sram_chip_enable   <= ce_n_d;
         sram_write_enable  <= we_n_d;
         sram_output_enable <= oe_n_d;
      end
   end

   // Write data stays on the bus through HOLD to give hold time after WE rises.
   assign sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

   assign bus.rdata = rdata_q;
   assign bus.ack   = ack_q;
   assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: WAIT_STATES=1 instance with a behavioural SRAM, plus 0 and 15 wait-state builds.
module tb_sram_controller;

   localparam int WS = 1;

   typedef struct {
      logic [7:0] rdata;
      int         we_low;
      int         oe_low;
   } sb_t;

   typedef struct {
      logic        w;
      logic [14:0] a;
      logic [7:0]  d;
      logic [7:0]  exp_rd;
   } vec_t;

   logic clk;
   logic reset;

   sram_controller_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) bus   ();
   sram_controller_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) bus0  ();
   sram_controller_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) bus15 ();

   logic [14:0] sa, sa0, sa15;
   wire  [7:0]  sd, sd0, sd15;
   logic        ce, wen, oe, ce0, wen0, oe0, ce15, wen15, oe15;

   sram_controller #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .reset(reset), .bus(bus), .sram_address(sa), .sram_data(sd),
      .sram_chip_enable(ce), .sram_write_enable(wen), .sram_output_enable(oe));

   sram_controller #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .sram_address(sa0), .sram_data(sd0),
      .sram_chip_enable(ce0), .sram_write_enable(wen0), .sram_output_enable(oe0));

   sram_controller #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .WAIT_STATES(15)) u_dut15 (
      .clk(clk), .reset(reset), .bus(bus15), .sram_address(sa15), .sram_data(sd15),
      .sram_chip_enable(ce15), .sram_write_enable(wen15), .sram_output_enable(oe15));

   // Behavioural 32Kx8 SRAM: drives on CE&OE low, writes on the rising edge of WE.
   logic [7:0] mem [0:32767];
   assign sd = (!ce && !oe) ? mem[sa] : 8'hzz;
   always @(posedge wen) if (!ce) mem[sa] = sd;

   // The short-strobe and long-strobe builds see a fixed address-derived pattern.
   assign sd0  = (!ce0  && !oe0)  ? (sa0[7:0]  ^ 8'h5A) : 8'hzz;
   assign sd15 = (!ce15 && !oe15) ? (sa15[7:0] ^ 8'h5A) : 8'hzz;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Scoreboard monitor for the main instance.
   sb_t        sb [$];
   int         we_low = 0, oe_low = 0, inv_err = 0;
   int         ack_cnt = 0, last_ack_cyc = 0, ack_gap = 0;
   logic       prev_ack = 1'b0, prev_busy = 1'b0;
   logic [14:0] prev_addr = '0;

   always @(negedge clk) begin
      sb_t e;
      if (reset) begin
         sb.delete();
         we_low    = 0;
         oe_low    = 0;
         prev_ack  = 1'b0;
         prev_busy = 1'b0;
      end else begin
         if (!wen) we_low++;
         if (!oe)  oe_low++;
         if (!wen && !oe) inv_err++;
         if (prev_ack && bus.ack) inv_err++;
         if (prev_busy && bus.busy && sa != prev_addr) inv_err++;
         if (bus.ack) begin
            ack_cnt++;
            ack_gap      = cyc - last_ack_cyc;
            last_ack_cyc = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_ack", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rdata",  int'(bus.rdata), int'(e.rdata));
               chk("we_low", we_low, e.we_low);
               chk("oe_low", oe_low, e.oe_low);
            end
            we_low = 0;
            oe_low = 0;
         end
         prev_ack  = bus.ack;
         prev_busy = bus.busy;
         prev_addr = sa;
      end
   end

   function automatic sb_t mk_exp(input logic w, input logic [7:0] rd);
      sb_t e;
      e.rdata  = rd;
      e.we_low = w ? WS + 1 : 0;
      e.oe_low = w ? 0 : WS + 1;
      return e;
   endfunction

   // Single access on the main instance; entered and left on a falling edge in IDLE.
   task automatic do_access(input logic w, input logic [14:0] a, input logic [7:0] d,
                            input logic [7:0] exp_rd, input string tag);
      int lat;
      sb.push_back(mk_exp(w, exp_rd));
      bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
      @(posedge clk); lat = 1;
      @(negedge clk); bus.req = 1'b0;
      while (!bus.ack && lat < 40) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      chk({tag, "_lat"}, lat, WS + 3);
      @(negedge clk);
   endtask

   // Read on the 0 (sel=0) or 15 (sel=1) wait-state build: latency, OE width, data.
   task automatic short_read(input int sel, input logic [14:0] a);
      int   lat, oe_cnt, ws;
      logic ack_s, oe_s;
      ws = (sel == 0) ? 0 : 15;
      if (sel == 0) begin bus0.req = 1'b1;  bus0.we = 1'b0;  bus0.addr = a;  end
      else          begin bus15.req = 1'b1; bus15.we = 1'b0; bus15.addr = a; end
      @(posedge clk); lat = 1; oe_cnt = 0;
      @(negedge clk); bus0.req = 1'b0; bus15.req = 1'b0;
      while (lat < 40) begin
         ack_s = (sel == 0) ? bus0.ack : bus15.ack;
         oe_s  = (sel == 0) ? oe0 : oe15;
         if (!oe_s) oe_cnt++;
         if (ack_s) break;
         @(posedge clk); lat++;
         @(negedge clk);
      end
      chk((sel == 0) ? "ws0_lat" : "ws15_lat", lat, ws + 3);
      chk((sel == 0) ? "ws0_oe_width" : "ws15_oe_width", oe_cnt, ws + 1);
      chk((sel == 0) ? "ws0_rdata" : "ws15_rdata",
          int'((sel == 0) ? bus0.rdata : bus15.rdata), int'(a[7:0] ^ 8'h5A));
      @(negedge clk);
   endtask

   vec_t vecs [7];

   initial begin
      int a0, n;
      vecs[0] = '{1'b1, 15'h1234, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 15'h1234, 8'h00, 8'hA5};
      vecs[2] = '{1'b1, 15'h0000, 8'h5A, 8'hA5};
      vecs[3] = '{1'b0, 15'h0000, 8'h00, 8'h5A};
      vecs[4] = '{1'b1, 15'h7FFF, 8'hFF, 8'h5A};
      vecs[5] = '{1'b0, 15'h7FFF, 8'h00, 8'hFF};
      vecs[6] = '{1'b0, 15'h1234, 8'h00, 8'hA5};

      reset = 1'b1;
      bus.req = 1'b0;   bus.we = 1'b0;   bus.addr = '0;   bus.wdata = '0;
      bus0.req = 1'b0;  bus0.we = 1'b0;  bus0.addr = '0;  bus0.wdata = '0;
      bus15.req = 1'b0; bus15.we = 1'b0; bus15.addr = '0; bus15.wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_strobes", int'({ce, wen, oe}), 3'b111);
      chk("rst_ack",     int'(bus.ack), 0);
      chk("rst_busy",    int'(bus.busy), 0);
      chk("rst_rdata",   int'(bus.rdata), 0);
      chk("rst_addr",    int'(sa), 0);

      for (int i = 0; i < 7; i++)
         do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, $sformatf("vec%0d", i));
      chk("rdata_held", int'(bus.rdata), 8'hA5);
      chk("mem_1234", int'(mem[15'h1234]), 8'hA5);

      // Asynchronous reset from IDLE: outputs clear without a clock edge.
      #2 reset = 1'b1;
      #1;
      chk("async_rst_rdata",   int'(bus.rdata), 0);
      chk("async_rst_strobes", int'({ce, wen, oe}), 3'b111);
      chk("async_rst_ack",     int'(bus.ack), 0);
      chk("async_rst_addr",    int'(sa), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Back-to-back with req held high: write then read of the top address.
      a0 = ack_cnt;
      sb.push_back(mk_exp(1'b1, 8'h00));
      sb.push_back(mk_exp(1'b0, 8'h3C));
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 15'h7FFF; bus.wdata = 8'h3C;
      @(negedge clk);
      bus.we = 1'b0; bus.wdata = 8'h00;
      n = 0;
      while (ack_cnt < a0 + 2 && n < 40) begin
         @(negedge clk); #1; n++;
         if (ack_cnt == a0 + 1 && bus.busy && !bus.ack) bus.req = 1'b0;
      end
      bus.req = 1'b0;
      chk("b2b_gap", ack_gap, WS + 4);
      repeat (8) @(negedge clk);
      chk("b2b_acks", ack_cnt - a0, 2);

      // Reset during the WE strobe of a write.
      sb.push_back(mk_exp(1'b1, 8'h00));
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 15'h0100; bus.wdata = 8'h77;
      @(posedge clk);
      @(negedge clk); bus.req = 1'b0;
      n = 0;
      while (wen && n < 20) begin @(negedge clk); n++; end
      chk("wr_strobe_seen", int'(wen), 0);
      a0 = ack_cnt;
      #2 reset = 1'b1;
      #1;
      chk("strobe_rst_strobes", int'({ce, wen, oe}), 3'b111);
      chk("strobe_rst_busy",    int'(bus.busy), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("strobe_rst_no_ack", ack_cnt - a0, 0);
      do_access(1'b1, 15'h0100, 8'h88, 8'h00, "post_rst_wr");
      do_access(1'b0, 15'h0100, 8'h00, 8'h88, "post_rst_rd");

      short_read(0, 15'h0042);
      short_read(1, 15'h01C3);

      chk("sb_drained", sb.size(), 0);
      chk("invariants", inv_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, %0d miscompares so far", n_err);
      $fatal(1, "timeout");
   end

endmodule
